// File: rtl/vram_image_loader_pkg.sv
// rtl/vram_image_loader_pkg.sv - shared constants and state type for the VRAM image loader
package mide_vram_pkg;

   localparam int unsigned ORIGINAL_PIXELS = 160000;
   localparam int unsigned SCALED_PIXELS   = 90000;
   localparam int          VRAM_ADDR_W     = 32;
   localparam int          PIXEL_W         = 8;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE
   } loader_state_t;

endpackage

// File: rtl/vram_image_loader_if.sv
// rtl/vram_image_loader_if.sv - pixel stream in and VRAM write port out of the image loader
interface vram_image_loader_if;
   import mide_vram_pkg::*;

   logic [PIXEL_W-1:0]     s_data;
   logic                   s_valid;
   logic                   s_ready;
   logic                   vram_we;
   logic [VRAM_ADDR_W-1:0] vram_addr;
   logic [PIXEL_W-1:0]     vram_wdata;

   modport master (
      output s_data,
      output s_valid,
      input  s_ready,
      input  vram_we,
      input  vram_addr,
      input  vram_wdata
   );

   modport slave (
      input  s_data,
      input  s_valid,
      output s_ready,
      output vram_we,
      output vram_addr,
      output vram_wdata
   );

endinterface

// File: rtl/vram_image_loader.sv
// rtl/vram_image_loader.sv - streams PIXELS bytes into consecutive VRAM addresses with a running checksum
module vram_image_loader
   import mide_vram_pkg::*;
#(
   parameter int unsigned             PIXELS    = ORIGINAL_PIXELS,
   parameter logic [VRAM_ADDR_W-1:0]  BASE_ADDR = '0,
   parameter int unsigned             CSUM_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   vram_image_loader_if.slave bus,
   output logic              busy,
   output logic              done,
   output logic [31:0]       pixel_count,
   output logic [CSUM_W-1:0] checksum
);

   localparam logic [31:0] LAST_COUNT = 32'(PIXELS - 1);

   loader_state_t state, state_next;
   logic          accept;
   logic          final_accept;

   // Ready is a pure state decode so the source never sees a path from its own valid.
   assign bus.s_ready  = (state == LOAD);
   assign busy         = (state == LOAD);
   assign done         = (state == DONE);
   assign accept       = (state == LOAD) && bus.s_valid;
   assign final_accept = accept && (pixel_count == LAST_COUNT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start)        state_next = LOAD;
         LOAD:    if (final_accept) state_next = DONE;
         DONE:    if (start)        state_next = LOAD;
         default:                   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.vram_we    <= 1'b0;
         bus.vram_addr  <= BASE_ADDR;
         bus.vram_wdata <= '0;
         pixel_count    <= '0;
         checksum       <= '0;
      end else begin
         bus.vram_we <= accept;
         if (accept) begin
            bus.vram_addr  <= BASE_ADDR + pixel_count;
            bus.vram_wdata <= bus.s_data;
            pixel_count    <= pixel_count + 32'd1;
            checksum       <= checksum + CSUM_W'(bus.s_data);
         end else if (start && (state != LOAD)) begin
            pixel_count <= '0;
            checksum    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vram_image_loader.sv
// tb/tb_vram_image_loader.sv - randomized self-checking bench for vram_image_loader
module tb_vram_image_loader;

   localparam int unsigned NP [3] = '{4, 40000, 1};
   localparam logic [31:0] NB [3] = '{32'h0000_0100, 32'hFFFF_C000, 32'h0000_0000};

   logic        clk;
   logic        rst_v   [3];
   logic        start_v [3];
   logic        sval    [3];
   logic [7:0]  sdat    [3];
   logic        rdy     [3];
   logic        we      [3];
   logic [31:0] addr    [3];
   logic [7:0]  wd      [3];
   logic        busy_v  [3];
   logic        done_v  [3];
   logic [31:0] cnt     [3];
   logic [15:0] csum    [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      vram_image_loader_if bus ();
      assign bus.s_data  = sdat[g];
      assign bus.s_valid = sval[g];
      assign rdy[g]      = bus.s_ready;
      assign we[g]       = bus.vram_we;
      assign addr[g]     = bus.vram_addr;
      assign wd[g]       = bus.vram_wdata;

      vram_image_loader #(
         .PIXELS    (NP[g]),
         .BASE_ADDR (NB[g]),
         .CSUM_W    (16)
      ) u_dut (
         .clk         (clk),
         .reset       (rst_v[g]),
         .start       (start_v[g]),
         .bus         (bus),
         .busy        (busy_v[g]),
         .done        (done_v[g]),
         .pixel_count (cnt[g]),
         .checksum    (csum[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: an image load is "the first PIXELS valid bytes after start",
   // written to BASE+index one cycle after each is taken.
   bit          m_load [3];
   bit          m_done [3];
   int unsigned m_cnt  [3];
   logic [15:0] m_sum  [3];

   task automatic step(input int k, input bit r, input bit st, input bit v, input logic [7:0] d);
      bit          exp_we;
      logic [31:0] exp_addr;
      logic [7:0]  exp_data;
      check_value($sformatf("u%0d.s_ready", k), 64'(rdy[k]), 64'(m_load[k]));
      rst_v[k]   = r;
      start_v[k] = st;
      sval[k]    = v;
      sdat[k]    = d;
      exp_we   = 1'b0;
      exp_addr = '0;
      exp_data = '0;
      if (r) begin
         m_load[k] = 0; m_done[k] = 0; m_cnt[k] = 0; m_sum[k] = '0;
      end else if (m_load[k]) begin
         if (v) begin
            exp_we   = 1'b1;
            exp_addr = NB[k] + m_cnt[k];
            exp_data = d;
            m_cnt[k] = m_cnt[k] + 1;
            m_sum[k] = m_sum[k] + 16'(d);
            if (m_cnt[k] == NP[k]) begin
               m_load[k] = 0;
               m_done[k] = 1;
            end
         end
      end else if (st) begin
         m_load[k] = 1; m_done[k] = 0; m_cnt[k] = 0; m_sum[k] = '0;
      end
      @(posedge clk);
      #1;
      rst_v[k]   = 1'b0;
      start_v[k] = 1'b0;
      sval[k]    = 1'b0;
      @(negedge clk);
      check_value($sformatf("u%0d.vram_we", k), 64'(we[k]), 64'(exp_we));
      if (exp_we) begin
         check_value($sformatf("u%0d.vram_addr", k), 64'(addr[k]), 64'(exp_addr));
         check_value($sformatf("u%0d.vram_wdata", k), 64'(wd[k]), 64'(exp_data));
      end
      if (r) begin
         check_value($sformatf("u%0d.reset_addr", k), 64'(addr[k]), 64'(NB[k]));
         check_value($sformatf("u%0d.reset_wdata", k), 64'(wd[k]), 64'h0);
      end
      check_value($sformatf("u%0d.busy", k), 64'(busy_v[k]), 64'(m_load[k]));
      check_value($sformatf("u%0d.done", k), 64'(done_v[k]), 64'(m_done[k]));
      check_value($sformatf("u%0d.pixel_count", k), 64'(cnt[k]), 64'(m_cnt[k]));
      check_value($sformatf("u%0d.checksum", k), 64'(csum[k]), 64'(m_sum[k]));
   endtask

   logic [7:0] pat [4];

   initial begin
      pat[0] = 8'hFF; pat[1] = 8'h01; pat[2] = 8'h10; pat[3] = 8'h20;
      for (int k = 0; k < 3; k++) begin
         rst_v[k] = 1'b1; start_v[k] = 1'b0; sval[k] = 1'b0; sdat[k] = '0;
         m_load[k] = 0; m_done[k] = 0; m_cnt[k] = 0; m_sum[k] = '0;
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) step(k, 1, 0, 0, 8'h00);

      // Back-to-back burst of the reference pattern.
      step(0, 0, 1, 0, 8'h00);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, pat[i]);
      check_value("u0.burst_checksum", 64'(csum[0]), 64'h0130);
      check_value("u0.burst_count", 64'(cnt[0]), 64'd4);
      check_value("u0.burst_done", 64'(done_v[0]), 64'd1);
      step(0, 0, 0, 0, 8'h00);

      // Valid toggling: idle cycles must not write.
      step(0, 0, 1, 0, 8'h00);
      for (int i = 0; i < 8; i++) step(0, 0, 0, (i % 2) == 0, pat[i / 2]);
      check_value("u0.toggle_checksum", 64'(csum[0]), 64'h0130);
      check_value("u0.toggle_last_addr", 64'(addr[0]), 64'h103);

      // Reset after the second accept aborts, then a fresh load starts at base.
      step(0, 0, 1, 0, 8'h00);
      step(0, 0, 0, 1, 8'h11);
      step(0, 0, 0, 1, 8'h22);
      step(0, 1, 0, 1, 8'h33);
      step(0, 0, 0, 1, 8'h44);
      step(0, 0, 1, 0, 8'h00);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, pat[i]);

      // Start during load (including on the final accept) is ignored; valid after done is ignored.
      step(0, 0, 1, 0, 8'h00);
      step(0, 0, 0, 1, 8'h05);
      step(0, 0, 1, 1, 8'h06);
      step(0, 0, 0, 1, 8'h07);
      step(0, 0, 1, 1, 8'h08);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'hAA);
      check_value("u0.after_done_count", 64'(cnt[0]), 64'd4);
      step(0, 0, 1, 1, 8'hBB);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8'($urandom));

      // Single-pixel image.
      step(2, 0, 1, 0, 8'h00);
      step(2, 0, 0, 1, 8'h7A);
      check_value("u2.single_checksum", 64'(csum[2]), 64'h007A);
      check_value("u2.single_done", 64'(done_v[2]), 64'd1);
      step(2, 0, 0, 1, 8'h55);

      // Randomized traffic with occasional start and reset pulses.
      for (int i = 0; i < 400; i++) begin
         step(0, ($urandom % 64) == 0, ($urandom % 12) == 0, ($urandom % 3) != 0, 8'($urandom));
         step(2, ($urandom % 64) == 0, ($urandom % 6) == 0, ($urandom % 2) != 0, 8'($urandom));
      end

      // Large image of 0xFF whose addresses wrap past 2^32.
      step(1, 0, 1, 0, 8'h00);
      for (int i = 0; i < int'(NP[1]); i++) step(1, 0, 0, 1, 8'hFF);
      check_value("u1.big_last_addr", 64'(addr[1]), 64'h0000_5C3F);
      check_value("u1.big_checksum", 64'(csum[1]), 64'hA3C0);
      check_value("u1.big_done", 64'(done_v[1]), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
